// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared register offsets and state type for the interrupt controller
//   No ports. Provides byte offsets of the register block and the controller state enum.
package irq_ctrl_pkg;

  // Byte offsets inside the 32-byte register window.
  localparam logic [4:0] OFS_ENABLE  = 5'h00;
  localparam logic [4:0] OFS_PENDING = 5'h04;
  localparam logic [4:0] OFS_CAUSE   = 5'h08;
  localparam logic [4:0] OFS_EOI     = 5'h0C;
  localparam logic [4:0] OFS_TRIGGER = 5'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder
//   req : NSRC request bits, bit 0 has highest priority
//   any : at least one request bit set
//   idx : index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [3:0]      idx
);

  always_comb begin
    any = |req;
    idx = 4'd0;
    // Scan downwards so the last assignment is the lowest set index.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller with claim / end-of-interrupt handshake
//   clk, reset     : clock, asynchronous active-low reset
//   rd, wr         : bus read / write strobes
//   addr, wdata    : bus byte address and write data
//   rdata          : combinational read data (0 unless a read hits a register)
//   irq_src        : raw interrupt requests, synchronous to clk
//   irqout         : registered interrupt request to the core, high exactly while in REQ
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0040
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] irq_src,
  output logic            irqout
);

  localparam logic [26:0] BASE_HI     = BASE_ADDR[31:5];
  localparam logic [2:0]  SEL_ENABLE  = OFS_ENABLE[4:2];
  localparam logic [2:0]  SEL_PENDING = OFS_PENDING[4:2];
  localparam logic [2:0]  SEL_CAUSE   = OFS_CAUSE[4:2];
  localparam logic [2:0]  SEL_EOI     = OFS_EOI[4:2];
  localparam logic [2:0]  SEL_TRIGGER = OFS_TRIGGER[4:2];

  irq_state_t      state_q, state_d;
  logic [NSRC-1:0] enable_q, pending_q, trigger_q, src_q;
  logic [NSRC-1:0] enable_d, pending_d, trigger_d;
  logic [NSRC-1:0] eligible, rise, w1c_mask, claim_mask;
  logic [3:0]      cur_src, win_idx;
  logic            win_any, hit, claim, eoi;
  logic [2:0]      sel;
  logic            unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  assign hit      = (addr[31:5] == BASE_HI);
  assign sel      = addr[4:2];
  assign eligible = pending_q & enable_q;
  assign rise     = irq_src & ~src_q;

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  assign claim = rd && hit && (sel == SEL_CAUSE) && (state_q == REQ) && win_any;
  assign eoi   = wr && hit && (sel == SEL_EOI) && (state_q == SERVICE);

  assign w1c_mask   = (wr && hit && (sel == SEL_PENDING)) ? wdata[NSRC-1:0] : '0;
  assign claim_mask = claim ? (NSRC'(1) << win_idx) : '0;
  assign enable_d   = (wr && hit && (sel == SEL_ENABLE)) ? wdata[NSRC-1:0] : enable_q;
  assign trigger_d  = (wr && hit && (sel == SEL_TRIGGER)) ? wdata[NSRC-1:0] : trigger_q;

  // Edge bits: a new rising edge wins over a same-cycle clear. Level bits follow the input.
  assign pending_d = (trigger_q & (rise | (pending_q & ~(w1c_mask | claim_mask))))
                   | (~trigger_q & irq_src);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = REQ;
      // Leaving REQ looks at next-cycle eligibility so a mask write or W1C drops
      // irqout on the very next edge.
      REQ: begin
        if (claim) state_d = SERVICE;
        else if ((pending_d & enable_d) == '0) state_d = IDLE;
      end
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irqout  <= 1'b0;
    end else begin
      state_q <= state_d;
      irqout  <= (state_d == REQ);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q  <= '0;
      pending_q <= '0;
      trigger_q <= '0;
      src_q     <= '0;
      cur_src   <= 4'd0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      trigger_q <= trigger_d;
      src_q     <= irq_src;
      if (claim) cur_src <= win_idx;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd && hit) begin
      case (sel)
        SEL_ENABLE:  rdata = 32'(enable_q);
        SEL_PENDING: rdata = 32'(pending_q);
        SEL_TRIGGER: rdata = 32'(trigger_q);
        SEL_CAUSE: begin
          if (claim) rdata = {1'b1, 27'd0, win_idx};
          else if (state_q == SERVICE) rdata = {28'd0, cur_src};
        end
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl with a behavioural reference model
module tb_irq_ctrl;

  localparam int          NSRC = 4;
  localparam logic [31:0] BASE = 32'h4000_0040;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rd = 1'b0;
  logic            wr = 1'b0;
  logic [31:0]     addr = 32'd0;
  logic [31:0]     wdata = 32'd0;
  logic [31:0]     rdata;
  logic [NSRC-1:0] irq_src = '0;
  logic            irqout;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_src (irq_src),
    .irqout  (irqout)
  );

  // Reference model: 0 = waiting, 1 = requesting, 2 = in service.
  logic [3:0] m_en = 4'd0, m_pend = 4'd0, m_trig = 4'd0, m_srcq = 4'd0, m_cur = 4'd0;
  int         m_state = 0;

  function automatic int first_set(input logic [3:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_rdata();
    int w;
    if (!rd || addr[31:5] != BASE[31:5]) return 32'd0;
    w = first_set(m_pend & m_en);
    case (addr[4:2])
      3'd0: return {28'd0, m_en};
      3'd1: return {28'd0, m_pend};
      3'd4: return {28'd0, m_trig};
      3'd2: begin
        if (m_state == 1 && w >= 0) return 32'h8000_0000 | 32'(w);
        if (m_state == 2) return {28'd0, m_cur};
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en = 4'd0; m_pend = 4'd0; m_trig = 4'd0; m_srcq = 4'd0; m_cur = 4'd0; m_state = 0;
    end else begin
      logic [3:0] np, ne, nt;
      int w, ns;
      bit hit, claim, eoi, w1c;
      hit   = (addr[31:5] == BASE[31:5]);
      w     = first_set(m_pend & m_en);
      claim = rd && hit && addr[4:2] == 3'd2 && m_state == 1 && w >= 0;
      eoi   = wr && hit && addr[4:2] == 3'd3 && m_state == 2;
      w1c   = wr && hit && addr[4:2] == 3'd1;
      ne    = (wr && hit && addr[4:2] == 3'd0) ? wdata[3:0] : m_en;
      nt    = (wr && hit && addr[4:2] == 3'd4) ? wdata[3:0] : m_trig;
      for (int i = 0; i < NSRC; i++) begin
        if (m_trig[i]) begin
          np[i] = m_pend[i];
          if (w1c && wdata[i]) np[i] = 1'b0;
          if (claim && w == i) np[i] = 1'b0;
          if (irq_src[i] && !m_srcq[i]) np[i] = 1'b1;
        end else begin
          np[i] = irq_src[i];
        end
      end
      ns = m_state;
      if (m_state == 0 && w >= 0) ns = 1;
      else if (m_state == 1 && claim) ns = 2;
      else if (m_state == 1 && (np & ne) == 4'd0) ns = 0;
      else if (m_state == 2 && eoi) ns = 0;
      if (claim) m_cur = 4'(w);
      m_en = ne; m_trig = nt; m_pend = np; m_srcq = irq_src; m_state = ns;
    end
  end

  int          n_vec = 0;
  int          n_bad = 0;
  logic        lit_rd_on = 1'b0, lit_irq_on = 1'b0, lit_irq_val = 1'b0;
  logic [31:0] lit_rd_val = 32'd0;
  string       lit_rd_name = "";

  always @(negedge clk) begin
    n_vec++;
    if (irqout !== (m_state == 1)) begin
      n_bad++;
      $display("FAIL model_irqout t=%0t actual=%b required=%b", $time, irqout, (m_state == 1));
    end
    n_vec++;
    if (rdata !== model_rdata()) begin
      n_bad++;
      $display("FAIL model_rdata t=%0t actual=%h required=%h", $time, rdata, model_rdata());
    end
    if (lit_rd_on) begin
      n_vec++;
      if (rdata !== lit_rd_val) begin
        n_bad++;
        $display("FAIL %s t=%0t actual=%h required=%h", lit_rd_name, $time, rdata, lit_rd_val);
      end
    end
    if (lit_irq_on) begin
      n_vec++;
      if (irqout !== lit_irq_val) begin
        n_bad++;
        $display("FAIL lit_irqout t=%0t actual=%b required=%b", $time, irqout, lit_irq_val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    rd = 1'b0;
    wr = 1'b0;
    lit_rd_on = 1'b0;
    lit_irq_on = 1'b0;
  endtask

  task automatic do_wr(input logic [4:0] ofs, input logic [31:0] d);
    wr = 1'b1;
    addr = BASE + {27'd0, ofs};
    wdata = d;
  endtask

  task automatic exp_rd(input logic [4:0] ofs, input logic [31:0] v, input string nm);
    rd = 1'b1;
    addr = BASE + {27'd0, ofs};
    lit_rd_on = 1'b1;
    lit_rd_val = v;
    lit_rd_name = nm;
  endtask

  task automatic exp_irq(input logic v);
    lit_irq_on = 1'b1;
    lit_irq_val = v;
  endtask

  task automatic pulse(input logic [3:0] s);
    irq_src = s; tick();
    irq_src = 4'd0; exp_irq(1'b0); tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state and address decode.
    exp_rd(5'h00, 32'd0, "rst_enable"); exp_irq(1'b0); tick();
    exp_rd(5'h04, 32'd0, "rst_pending"); tick();
    exp_rd(5'h10, 32'd0, "rst_trigger"); tick();
    exp_rd(5'h08, 32'd0, "rst_cause"); tick();
    do_wr(5'h14, 32'hF); tick();
    do_wr(5'h00, 32'hF); addr = 32'h4000_0000; tick();
    exp_rd(5'h00, 32'd0, "miss_write_ignored"); tick();
    exp_rd(5'h14, 32'd0, "unmapped_read"); tick();

    // Edge path on source 1.
    do_wr(5'h10, 32'hF); tick();
    do_wr(5'h00, 32'h2); tick();
    pulse(4'b0010);
    exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0001, "edge_claim"); tick();
    exp_irq(1'b0); exp_rd(5'h04, 32'd0, "edge_pending_cleared"); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b0); exp_rd(5'h08, 32'd0, "edge_cause_idle"); tick();

    // Priority: sources 3 and 0 together.
    do_wr(5'h00, 32'hF); tick();
    pulse(4'b1001);
    exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0000, "prio_first_claim"); tick();
    exp_rd(5'h08, 32'h0000_0000, "prio_service_cause"); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0003, "prio_second_claim"); tick();
    exp_rd(5'h08, 32'h0000_0003, "prio_debug_cur_src"); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();

    // Level mode on source 2.
    do_wr(5'h10, 32'hB); tick();
    irq_src = 4'b0100; tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0002, "level_claim"); tick();
    exp_rd(5'h04, 32'h4, "level_pending_kept"); tick();
    do_wr(5'h04, 32'h4); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0002, "level_reclaim"); tick();
    irq_src = 4'd0; tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b0); exp_rd(5'h04, 32'd0, "level_pending_dropped"); tick();

    // Mask and W1C while requesting.
    do_wr(5'h10, 32'hF); tick();
    do_wr(5'h00, 32'h2); tick();
    pulse(4'b0010);
    exp_irq(1'b1); do_wr(5'h00, 32'd0); tick();
    exp_irq(1'b0); exp_rd(5'h04, 32'h2, "mask_pending_kept"); tick();
    do_wr(5'h00, 32'h2); tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b1); do_wr(5'h04, 32'h2); tick();
    exp_irq(1'b0); exp_rd(5'h04, 32'd0, "w1c_pending"); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); tick();

    // New edge colliding with the claim of the same source.
    pulse(4'b0010);
    irq_src = 4'b0010; exp_irq(1'b1); exp_rd(5'h08, 32'h8000_0001, "coll_claim"); tick();
    irq_src = 4'd0; exp_irq(1'b0); exp_rd(5'h04, 32'h2, "coll_pending_kept"); tick();
    exp_rd(5'h08, 32'h0000_0001, "coll_service_cause"); tick();

    // Reset in the middle of service.
    reset = 1'b0; tick();
    exp_irq(1'b0); tick();
    reset = 1'b1; tick();
    exp_rd(5'h00, 32'd0, "svc_rst_enable"); exp_irq(1'b0); tick();
    exp_rd(5'h04, 32'd0, "svc_rst_pending"); tick();
    exp_rd(5'h10, 32'd0, "svc_rst_trigger"); tick();
    exp_rd(5'h08, 32'd0, "svc_rst_cause"); tick();
    do_wr(5'h0C, 32'd0); tick();
    exp_irq(1'b0); exp_rd(5'h08, 32'd0, "post_rst_eoi"); tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
